// File: rtl/seven_segment_capture.sv
// Receive-side decoder for a multiplexed four-digit seven-segment bus: waits for each
// strobed digit to settle, decodes its glyph back to a nibble and tracks frame/stale status.
module seven_segment_capture #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            segA,
   input  logic            segB,
   input  logic            segC,
   input  logic            segD,
   input  logic            segE,
   input  logic            segF,
   input  logic            segG,
   input  logic [3:0]      dsen,
   output logic [3:0][3:0] bcd,
   output logic [3:0]      digit_ok,
   output logic            frame_valid,
   output logic            stale
);

   localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   logic [10:0] raw;
   logic [10:0] sync1;
   logic [10:0] s;
   logic [10:0] p;
   logic [7:0]  cnt;
   logic        armed;
   logic [15:0] tcnt;
   logic [3:0]  seen;

   logic        s_onehot;
   logic        p_onehot;
   logic        capture;
   logic        glyph_ok;
   logic        timed_out;
   logic [3:0]  nibble;
   logic [1:0]  idx;

   function automatic logic onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [1:0] digit_index(input logic [3:0] v);
      case (v)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Returns {recognized, nibble}; unrecognized patterns decode to nibble 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] g);
      case (g)
         7'b1111110: return 5'h10;
         7'b0110000: return 5'h11;
         7'b1101101: return 5'h12;
         7'b1111001: return 5'h13;
         7'b0110011: return 5'h14;
         7'b1011011: return 5'h15;
         7'b1011111: return 5'h16;
         7'b1110000: return 5'h17;
         7'b1111111: return 5'h18;
         7'b1111011: return 5'h19;
         7'b1110111: return 5'h1A;
         7'b0011111: return 5'h1B;
         7'b1001110: return 5'h1C;
         7'b0111101: return 5'h1D;
         7'b1001111: return 5'h1E;
         7'b1000111: return 5'h1F;
         default:    return 5'h00;
      endcase
   endfunction

   assign raw = {dsen, segA, segB, segC, segD, segE, segF, segG};

   // Decode from p: when a dwell ends exactly on the capture cycle, p still holds the settled value.
   always_comb begin
      s_onehot             = onehot(s[10:7]);
      p_onehot             = onehot(p[10:7]);
      capture              = (cnt == SETTLE_C) && armed && p_onehot;
      {glyph_ok, nibble}   = decode_glyph(p[6:0]);
      idx                  = digit_index(p[10:7]);
      timed_out            = (tcnt == TIMEOUT_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
         p     <= '0;
      end else begin
         sync1 <= raw;
         s     <= sync1;
         p     <= s;
      end
   end

   // Any change or a non-one-hot strobe restarts the dwell and re-arms a single capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= 8'd0;
         armed <= 1'b1;
      end else if ((s != p) || !s_onehot) begin
         cnt   <= 8'd0;
         armed <= 1'b1;
      end else begin
         if (cnt != SETTLE_C) begin
            cnt <= cnt + 8'd1;
         end
         if (capture) begin
            armed <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd         <= '0;
         digit_ok    <= 4'b0000;
         frame_valid <= 1'b0;
         stale       <= 1'b1;
         tcnt        <= 16'd0;
         seen        <= 4'b0000;
      end else begin
         frame_valid <= (seen == 4'b1111);
         if (capture) begin
            bcd[idx]      <= nibble;
            digit_ok[idx] <= glyph_ok;
            tcnt          <= 16'd0;
            stale         <= 1'b0;
            seen          <= ((seen == 4'b1111) ? 4'b0000 : seen) | p[10:7];
         end else begin
            if (!timed_out) begin
               tcnt <= tcnt + 16'd1;
            end
            if (timed_out) begin
               stale    <= 1'b1;
               digit_ok <= 4'b0000;
               seen     <= 4'b0000;
            end else if (seen == 4'b1111) begin
               seen <= 4'b0000;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboarded bench for seven_segment_capture: expected captures are queued with their
// due cycle when a digit is strobed and checked by a negedge monitor when they land.
module tb_seven_segment_capture;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 50;
   localparam int LAT     = SETTLE + 4;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   typedef struct {
      int         due;
      int         idx;
      logic [3:0] nib;
      logic       ok;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [6:0]      seg = 7'b0;
   logic [3:0]      dsen = 4'b0;
   logic [3:0][3:0] bcd;
   logic [3:0]      digit_ok;
   logic            frame_valid;
   logic            stale;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   fv_count = 0;
   int   fv_cyc = -1;
   exp_t sb[$];
   exp_t mon_e;
   logic [3:0] model_bcd [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

   seven_segment_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .segA(seg[6]), .segB(seg[5]), .segC(seg[4]), .segD(seg[3]),
      .segE(seg[2]), .segF(seg[1]), .segG(seg[0]),
      .dsen(dsen), .bcd(bcd), .digit_ok(digit_ok),
      .frame_valid(frame_valid), .stale(stale)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: pops every expectation whose due cycle has arrived.
   always @(negedge clk) begin
      if (!rst) begin
         while (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (bcd[mon_e.idx] !== mon_e.nib || digit_ok[mon_e.idx] !== mon_e.ok) begin
               failures++;
               $display("[TB] FAIL capture_d%0d cyc=%0d: got bcd=%h ok=%b, want bcd=%h ok=%b",
                        mon_e.idx, cyc, bcd[mon_e.idx], digit_ok[mon_e.idx], mon_e.nib, mon_e.ok);
            end
            model_bcd[mon_e.idx] = mon_e.nib;
         end
         if (frame_valid) begin
            fv_count++;
            fv_cyc = cyc;
         end
      end
   end

   task automatic drive_digit(input int idx, input logic [6:0] pat, input logic [3:0] nib,
                              input logic ok, input int hold, output int t);
      exp_t e;
      @(negedge clk);
      dsen  = 4'(1 << idx);
      seg   = pat;
      t     = cyc;
      e.due = cyc + LAT;
      e.idx = idx;
      e.nib = nib;
      e.ok  = ok;
      sb.push_back(e);
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic go_idle(input int n);
      @(negedge clk);
      dsen = 4'b0000;
      seg  = 7'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (sb.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("[TB] FAIL %s_drain: %0d captures never arrived, want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if (bcd !== 16'h0000 || digit_ok !== 4'b0000 || frame_valid !== 1'b0 || stale !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_values: got bcd=%h ok=%b fv=%b stale=%b, want 0000/0000/0/1",
                  bcd, digit_ok, frame_valid, stale);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (stale !== 1'b1 || digit_ok !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL idle_after_reset: got stale=%b ok=%b, want 1/0000", stale, digit_ok);
      end
   endtask

   task automatic test_basic_scan;
      exp_t e;
      int   t;
      int   fv0;
      fv0 = fv_count;
      @(negedge clk);
      dsen  = 4'b0001;
      seg   = GLYPH[1];
      e.due = cyc + LAT;
      e.idx = 0;
      e.nib = 4'h1;
      e.ok  = 1'b1;
      sb.push_back(e);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (bcd[0] !== 4'h0 || digit_ok[0] !== 1'b0 || stale !== 1'b1) begin
         failures++;
         $display("[TB] FAIL early_capture: got bcd0=%h ok0=%b stale=%b one cycle early, want 0/0/1",
                  bcd[0], digit_ok[0], stale);
      end
      @(negedge clk);
      checks++;
      if (stale !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stale_fall: got stale=%b at first capture, want 0", stale);
      end
      repeat (10 - LAT - 1) @(negedge clk);
      drive_digit(1, GLYPH[2], 4'h2, 1'b1, 10, t);
      drive_digit(2, GLYPH[3], 4'h3, 1'b1, 10, t);
      drive_digit(3, GLYPH[4], 4'h4, 1'b1, 10, t);
      go_idle(5);
      drain("basic");
      checks++;
      if (bcd !== 16'h4321 || digit_ok !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL basic_frame: got bcd=%h ok=%b, want 4321/1111", bcd, digit_ok);
      end
      checks++;
      if (fv_count !== fv0 + 1 || fv_cyc !== t + LAT + 1) begin
         failures++;
         $display("[TB] FAIL basic_frame_valid: got %0d pulses last at cyc %0d, want 1 at cyc %0d",
                  fv_count - fv0, fv_cyc, t + LAT + 1);
      end
   endtask

   task automatic test_glyph_sweep;
      int t;
      for (int n = 0; n < 16; n++) begin
         drive_digit(0, GLYPH[n], 4'(n), 1'b1, 8, t);
      end
      drive_digit(0, 7'b0000000, 4'h0, 1'b0, 8, t);
      drive_digit(0, 7'b1010101, 4'h0, 1'b0, 8, t);
      drain("sweep");
   endtask

   task automatic test_short_dwell_glitch;
      exp_t       e;
      logic [3:0] prev;
      int         transitions;
      @(negedge clk);
      dsen = 4'b0010;
      seg  = GLYPH[7];
      repeat (3) @(negedge clk);
      dsen = 4'b0000;
      repeat (12) @(negedge clk);
      checks++;
      if (bcd[1] !== 4'h2 || digit_ok[1] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL short_dwell: got bcd1=%h ok1=%b, want 2/1 unchanged", bcd[1], digit_ok[1]);
      end
      prev        = bcd[2];
      transitions = 0;
      dsen = 4'b0100;
      seg  = GLYPH[5];
      repeat (2) @(negedge clk);
      seg = GLYPH[5] ^ 7'b0000001;
      @(negedge clk);
      seg   = GLYPH[9];
      e.due = cyc + LAT;
      e.idx = 2;
      e.nib = 4'h9;
      e.ok  = 1'b1;
      sb.push_back(e);
      for (int i = 0; i < LAT + 6; i++) begin
         @(negedge clk);
         if (bcd[2] !== prev) transitions++;
         prev = bcd[2];
      end
      checks++;
      if (transitions !== 1) begin
         failures++;
         $display("[TB] FAIL glitch_single_capture: got %0d bcd2 changes, want 1", transitions);
      end
      drain("glitch");
   endtask

   task automatic test_invalid_strobes;
      int bad = 0;
      int fv0;
      fv0 = fv_count;
      @(negedge clk);
      dsen = 4'b0011;
      seg  = GLYPH[8];
      for (int i = 0; i < 40; i++) begin
         if (i == 20) dsen = 4'b0000;
         @(negedge clk);
         for (int j = 0; j < 4; j++) begin
            if (bcd[j] !== model_bcd[j]) bad++;
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL invalid_strobe_bcd: got %0d changed nibble samples, want 0", bad);
      end
      checks++;
      if (fv_count !== fv0) begin
         failures++;
         $display("[TB] FAIL invalid_strobe_frame: got %0d pulses, want 0", fv_count - fv0);
      end
   endtask

   task automatic test_timeout;
      exp_t e;
      int   t;
      int   fv0;
      fv0 = fv_count;
      drive_digit(0, GLYPH[10], 4'hA, 1'b1, 10, t);
      drive_digit(1, GLYPH[11], 4'hB, 1'b1, 10, t);
      drive_digit(2, GLYPH[12], 4'hC, 1'b1, 10, t);
      drive_digit(3, GLYPH[13], 4'hD, 1'b1, 10, t);
      @(negedge clk);
      dsen = 4'b0000;
      while (cyc < t + LAT + TIMEOUT) @(negedge clk);
      checks++;
      if (stale !== 1'b0 || digit_ok !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL pre_timeout: got stale=%b ok=%b, want 0/1111", stale, digit_ok);
      end
      checks++;
      if (fv_count !== fv0 + 1) begin
         failures++;
         $display("[TB] FAIL timeout_frame: got %0d pulses, want 1", fv_count - fv0);
      end
      @(negedge clk);
      checks++;
      if (stale !== 1'b1 || digit_ok !== 4'b0000 || bcd !== 16'hDCBA) begin
         failures++;
         $display("[TB] FAIL timeout: got stale=%b ok=%b bcd=%h, want 1/0000/dcba", stale, digit_ok, bcd);
      end
      fv0 = fv_count;
      @(negedge clk);
      dsen  = 4'b0010;
      seg   = GLYPH[7];
      e.due = cyc + LAT;
      e.idx = 1;
      e.nib = 4'h7;
      e.ok  = 1'b1;
      sb.push_back(e);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (stale !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stale_hold: got stale=%b before recapture, want 1", stale);
      end
      @(negedge clk);
      checks++;
      if (stale !== 1'b0 || digit_ok !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL recapture: got stale=%b ok=%b, want 0/0010", stale, digit_ok);
      end
      go_idle(20);
      checks++;
      if (fv_count !== fv0) begin
         failures++;
         $display("[TB] FAIL partial_frame: got %0d pulses after one digit, want 0", fv_count - fv0);
      end
      drive_digit(0, GLYPH[0], 4'h0, 1'b1, 10, t);
      drive_digit(2, GLYPH[5], 4'h5, 1'b1, 10, t);
      drive_digit(3, GLYPH[6], 4'h6, 1'b1, 10, t);
      go_idle(4);
      drain("timeout");
      checks++;
      if (fv_count !== fv0 + 1 || bcd !== 16'h6570) begin
         failures++;
         $display("[TB] FAIL refill_frame: got %0d pulses bcd=%h, want 1/6570", fv_count - fv0, bcd);
      end
   endtask

   task automatic test_reset_midrun;
      @(negedge clk);
      dsen = 4'b0001;
      seg  = GLYPH[6];
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bcd !== 16'h0000 || digit_ok !== 4'b0000 || stale !== 1'b1 || frame_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrun_reset: got bcd=%h ok=%b stale=%b fv=%b, want 0000/0000/1/0",
                  bcd, digit_ok, stale, frame_valid);
      end
      dsen = 4'b0000;
      seg  = 7'b0;
      sb.delete();
      for (int j = 0; j < 4; j++) model_bcd[j] = 4'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (bcd !== 16'h0000 || stale !== 1'b1 || digit_ok !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL post_reset_idle: got bcd=%h stale=%b ok=%b, want 0000/1/0000",
                  bcd, stale, digit_ok);
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_glyph_sweep();
      test_short_dwell_glitch();
      test_invalid_strobes();
      test_timeout();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
